// File: rtl/command_sequencer.sv
// Mode sequencer for life support: pilot requests gated by a dwell timer, forced
// exits on low power / over-temperature, fatal lockout, recharge and O2 supply pulses.
module command_sequencer #(
  parameter int unsigned n       = 32,
  parameter int unsigned PWR_LOW = 10,
  parameter int unsigned O2_LOW  = 20,
  parameter int unsigned TEMP_HI = 90,
  parameter int unsigned HOLD    = 8,
  parameter int unsigned GAP     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_def,
  input  logic         req_sth,
  input  logic         req_cru,
  input  logic         dock,
  input  logic [n-1:0] power,
  input  logic [n-1:0] o2,
  input  logic [n-1:0] temp,
  input  logic         fatal,
  output logic [3:0]   mode,
  output logic         chrg,
  output logic         o2sup,
  output logic         warn,
  output logic         alarm
);

  localparam int unsigned DW = $clog2(HOLD + 1);
  localparam int unsigned GW = $clog2(GAP + 1);
  localparam logic [n-1:0]  PWR_LOW_V = n'(PWR_LOW);
  localparam logic [n-1:0]  O2_LOW_V  = n'(O2_LOW);
  localparam logic [n-1:0]  TEMP_HI_V = n'(TEMP_HI);
  localparam logic [DW-1:0] HOLD_V    = DW'(HOLD);
  localparam logic [GW-1:0] GAP_LD    = GW'(GAP - 1);

  typedef enum logic [1:0] {CRUISE, DEFENSE, STEALTH, SAFE} state_t;

  state_t        state, state_nxt, req_tgt;
  logic          req_vld;
  logic [DW-1:0] dwell;
  logic [GW-1:0] gap;
  logic          dock_q;
  logic          pwr_low, o2_low, temp_hi;
  logic          fire, chrg_nxt;
  logic [3:0]    mode_nxt;

  always_comb begin
    pwr_low = (power <= PWR_LOW_V);
    o2_low  = (o2 <= O2_LOW_V);
    temp_hi = (temp >= TEMP_HI_V);

    // The highest-priority asserted request is the only candidate; if it is
    // blocked or already current it is dropped rather than falling through.
    req_vld = 1'b1;
    req_tgt = CRUISE;
    if (req_def)      req_tgt = DEFENSE;
    else if (req_sth) req_tgt = STEALTH;
    else if (req_cru) req_tgt = CRUISE;
    else              req_vld = 1'b0;
    if ((req_tgt == DEFENSE || req_tgt == STEALTH) && pwr_low) req_vld = 1'b0;
    if (req_tgt == STEALTH && temp_hi) req_vld = 1'b0;
    if (req_tgt == state) req_vld = 1'b0;
    if (dwell != HOLD_V) req_vld = 1'b0;

    state_nxt = state;
    if (fatal) begin
      state_nxt = SAFE;
    end else begin
      case (state)
        SAFE:    state_nxt = SAFE;
        DEFENSE: begin
          if (pwr_low)      state_nxt = CRUISE;
          else if (req_vld) state_nxt = req_tgt;
        end
        STEALTH: begin
          if (pwr_low || temp_hi) state_nxt = CRUISE;
          else if (req_vld)       state_nxt = req_tgt;
        end
        default: begin
          if (req_vld) state_nxt = req_tgt;
        end
      endcase
    end

    fire     = o2_low && (gap == '0) && (state_nxt != SAFE);
    chrg_nxt = dock && !dock_q && (state_nxt != SAFE);

    case (state_nxt)
      DEFENSE: mode_nxt = 4'b0100;
      STEALTH: mode_nxt = 4'b1000;
      default: mode_nxt = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= CRUISE;
      dwell  <= '0;
      gap    <= '0;
      dock_q <= 1'b0;
      mode   <= 4'b0000;
      chrg   <= 1'b0;
      o2sup  <= 1'b0;
      warn   <= 1'b0;
      alarm  <= 1'b0;
    end else begin
      state  <= state_nxt;
      if (state_nxt != state) dwell <= '0;
      else if (dwell != HOLD_V) dwell <= dwell + 1'b1;
      if (fire) gap <= GAP_LD;
      else if (gap != '0) gap <= gap - 1'b1;
      dock_q <= dock;
      mode   <= mode_nxt;
      chrg   <= chrg_nxt;
      o2sup  <= fire;
      warn   <= pwr_low | o2_low | temp_hi;
      alarm  <= (state_nxt == SAFE);
    end
  end

endmodule

// File: doc/command_sequencer.md
COMMAND_SEQUENCER -- requirements
Module: command_sequencer

Interface
REQ-001 Parameter n, default 32: width of all telemetry inputs.
REQ-002 Parameter PWR_LOW, default 10: power at or below this is low.
REQ-003 Parameter O2_LOW, default 20: O2 at or below this triggers a supply request.
REQ-004 Parameter TEMP_HI, default 90: temperature at or above this forces stealth exit.
REQ-005 Parameter HOLD, default 8: minimum dwell cycles before a pilot-requested mode change.
REQ-006 Parameter GAP, default 16: minimum cycles between o2sup pulses.
REQ-007 Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req_def  in  1  pilot request: defense.
- req_sth  in  1  pilot request: stealth.
- req_cru  in  1  pilot request: cruise.
- dock  in  1  docking-station contact level.
- power  in  n  life-support power telemetry, unsigned.
- o2  in  n  life-support O2 telemetry, unsigned.
- temp  in  n  life-support temperature telemetry, unsigned.
- fatal  in  1  life-support fatal flag.
- mode  out  4  mode code to life support.
- chrg  out  1  one-cycle recharge pulse.
- o2sup  out  1  one-cycle O2 supply pulse.
- warn  out  1  registered low-resource or over-temperature warning.
- alarm  out  1  registered safe-state indicator.

Function
REQ-008 All outputs SHALL be registered; every input is sampled at the rising clk edge, and the response appears in the following cycle.
REQ-009 FSM states SHALL be CRUISE, DEFENSE, STEALTH and SAFE; mode SHALL be 4'b0000, 4'b0100, 4'b1000 and 4'b0000 respectively.
REQ-010 Transition priority, highest first, SHALL be: fatal, forced exit, pilot request.
REQ-011 fatal=1 in any state SHALL move the FSM to SAFE; SAFE is left only by rst.
REQ-012 In DEFENSE or STEALTH, power<=PWR_LOW SHALL force CRUISE regardless of the dwell count.
REQ-013 In STEALTH, temp>=TEMP_HI SHALL force CRUISE regardless of the dwell count.
REQ-014 Pilot requests SHALL be honoured only when dwell==HOLD.
- Request priority: req_def > req_sth > req_cru.
- A request for the current state is ignored.
REQ-015 Requests to enter DEFENSE or STEALTH SHALL be ignored while power<=PWR_LOW.
REQ-016 Requests to enter STEALTH SHALL be ignored while temp>=TEMP_HI.
REQ-017 dwell SHALL be a counter that clears to 0 on every state change, increments each cycle otherwise, and saturates at HOLD.
REQ-018 Ignored requests SHALL NOT be queued.
REQ-019 chrg SHALL pulse high for exactly one cycle following each 0->1 transition of dock, using a registered previous value of dock.
- A dock held high produces one pulse only.
- No chrg pulse is issued in SAFE.
REQ-020 The gap counter and o2sup SHALL behave as follows:
- The gap counter loads GAP-1 when o2sup fires, decrements to 0 and holds at 0.
- o2sup SHALL pulse for one cycle when o2<=O2_LOW and the gap counter is 0.
- No o2sup pulse is issued in SAFE.
REQ-021 warn SHALL equal the registered value of (power<=PWR_LOW) | (o2<=O2_LOW) | (temp>=TEMP_HI).
REQ-022 alarm SHALL be 1 exactly while the FSM is in SAFE.
REQ-023 All threshold comparisons SHALL be unsigned at full width n; no counter wraps.

Reset
REQ-024 rst=1 at a clock edge SHALL set:
- FSM state to CRUISE;
- mode=4'b0000, chrg=0, o2sup=0, warn=0, alarm=0;
- dwell=0, gap counter=0, registered dock=0.
REQ-025 rst SHALL take priority over fatal and all other inputs, including mid-dwell and mid-gap.
REQ-026 In the first cycle after rst deasserts, a dock already high SHALL produce a chrg pulse, because registered dock resets to 0.

Verification
REQ-027 Dwell gating: power=100, req_def pulsed at dwell=3 -> mode stays 0000; req_def held until dwell=8 -> mode=0100 on the next cycle, and dwell restarts at 0.
REQ-028 Stealth forced exit: in STEALTH with power=100, temp stepped 89->90 -> mode returns to 0000 one cycle later, and warn=1.
REQ-029 Fatal lockout: fatal=1 for one cycle in DEFENSE -> mode=0000 and alarm=1; both persist with all requests and dock toggles ignored until rst.
REQ-030 O2 spacing: o2 held at 5 -> o2sup pulses at cycle k, then at cycles k+16 and k+32, with no pulses in between.
REQ-031 Charge edge: dock 0->1 held for 20 cycles -> exactly one chrg pulse; dock 1->0->1 -> a second pulse.
REQ-032 Power-low entry block: power=10, req_sth held with dwell saturated -> mode stays 0000; power raised to 11 -> mode=1000 on the next cycle.
